// File: rtl/adc_data_format.sv
// ADC lane formatter: per-sample offset-binary -> two's complement, 1+PIPE_DEPTH cycle latency, no backpressure.
// Output validity is gated until SETTLE_CYCLES valid words have been seen after reset; ramp checker under ADC_DATA_FORMAT_RAMP_CHECK_EN.
module adc_data_format #(
  parameter int NCHAN         = 4,
  parameter int SERDES_RATIO  = 8,
  parameter int SAMPLE_W      = 10,
  parameter int PIPE_DEPTH    = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                                   clk_div_a,
  input  logic                                   rst,
  input  logic                                   fmt_signed,
  input  logic [NCHAN*SERDES_RATIO*SAMPLE_W-1:0] din,
  input  logic                                   din_valid,
  output logic [NCHAN*SERDES_RATIO*SAMPLE_W-1:0] dout,
  output logic                                   dout_valid,
  output logic                                   flag,
  input  logic                                   err_clr,
  output logic [15:0]                            ramp_err_cnt
);

  localparam int DW = NCHAN * SERDES_RATIO * SAMPLE_W;
  localparam int NS = NCHAN * SERDES_RATIO;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  function automatic logic [DW-1:0] msb_mask();
    logic [DW-1:0] m;
    m = '0;
    for (int s = 0; s < NS; s++) m[s*SAMPLE_W+SAMPLE_W-1] = 1'b1;
    return m;
  endfunction

  localparam logic [DW-1:0] MSB_MASK = msb_mask();

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q;

  always_ff @(posedge clk_div_a) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   state_d = SETTLE;
      SETTLE: begin
        if (din_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = RUN;
        end
      end
      RUN:    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign flag = flag_q;

  // Subtracting 2^(SAMPLE_W-1) modulo 2^SAMPLE_W is exactly an MSB flip.
  logic [DW-1:0] conv;
  assign conv = din ^ (fmt_signed ? MSB_MASK : '0);

  logic [DW-1:0]     dat_q [PIPE_DEPTH+1];
  logic [PIPE_DEPTH:0] vld_q;

  always_ff @(posedge clk_div_a) begin
    if (rst) begin
      for (int i = 0; i <= PIPE_DEPTH; i++) dat_q[i] <= '0;
      vld_q <= '0;
    end else begin
      dat_q[0] <= conv;
      vld_q[0] <= din_valid && (state_q == RUN);
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign dout       = dat_q[PIPE_DEPTH];
  assign dout_valid = vld_q[PIPE_DEPTH];

`ifdef ADC_DATA_FORMAT_RAMP_CHECK_EN
  logic [SAMPLE_W-1:0] last_q [NCHAN];
  logic [SAMPLE_W-1:0] last_d [NCHAN];
  logic                have_prev_q, have_prev_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [16:0]         sum_c;
  logic                bad_c;
  logic                chk_c;

  always_comb begin
    chk_c       = din_valid && (state_q == RUN);
    sum_c       = {1'b0, err_cnt_q};
    bad_c       = 1'b0;
    have_prev_d = have_prev_q | chk_c;
    for (int c = 0; c < NCHAN; c++) begin
      last_d[c] = last_q[c];
      // Cross-word continuity only once a previous RUN word exists.
      bad_c = have_prev_q &&
              (din[c*SERDES_RATIO*SAMPLE_W +: SAMPLE_W] != SAMPLE_W'(last_q[c] + 1'b1));
      for (int k = 0; k < SERDES_RATIO - 1; k++) begin
        if (din[(c*SERDES_RATIO+k+1)*SAMPLE_W +: SAMPLE_W] !=
            SAMPLE_W'(din[(c*SERDES_RATIO+k)*SAMPLE_W +: SAMPLE_W] + 1'b1))
          bad_c = 1'b1;
      end
      if (chk_c) begin
        last_d[c] = din[(c*SERDES_RATIO+SERDES_RATIO-1)*SAMPLE_W +: SAMPLE_W];
        if (bad_c) sum_c = sum_c + 17'd1;
      end
    end
    if (err_clr)       err_cnt_d = '0;
    else if (sum_c[16]) err_cnt_d = 16'hFFFF;
    else               err_cnt_d = sum_c[15:0];
  end

  always_ff @(posedge clk_div_a) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) last_q[c] <= '0;
      have_prev_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) last_q[c] <= last_d[c];
      have_prev_q <= have_prev_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ramp_err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ramp_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_adc_data_format.sv
// Scoreboard bench for adc_data_format: default instance plus a small reduced-parameter instance.
module tb_adc_data_format;

  localparam int NCH = 4, SR = 8, SW = 10, PD = 2, SC = 16;
  localparam int W1 = NCH * SR * SW;
  localparam int W2 = 2 * 4 * 12;
`ifdef ADC_DATA_FORMAT_RAMP_CHECK_EN
  localparam int RAMP_ON = 1;
`else
  localparam int RAMP_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, fmt_signed = 1'b0, din_valid = 1'b0, err_clr = 1'b0;
  logic [W1-1:0] din = '0, dout;
  logic          dout_valid, flag;
  logic [15:0]   ramp_err_cnt;

  logic          rst2 = 1'b1, fmt2 = 1'b0, dv2 = 1'b0, ec2 = 1'b0;
  logic [W2-1:0] din2 = '0, dout2;
  logic          dov2, flag2;
  logic [15:0]   rc2;

  adc_data_format #(.NCHAN(NCH), .SERDES_RATIO(SR), .SAMPLE_W(SW), .PIPE_DEPTH(PD),
                    .SETTLE_CYCLES(SC)) dut (
    .clk_div_a(clk), .rst(rst), .fmt_signed(fmt_signed), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .flag(flag), .err_clr(err_clr),
    .ramp_err_cnt(ramp_err_cnt));

  adc_data_format #(.NCHAN(2), .SERDES_RATIO(4), .SAMPLE_W(12), .PIPE_DEPTH(0),
                    .SETTLE_CYCLES(2)) dut2 (
    .clk_div_a(clk), .rst(rst2), .fmt_signed(fmt2), .din(din2), .din_valid(dv2),
    .dout(dout2), .dout_valid(dov2), .flag(flag2), .err_clr(ec2), .ramp_err_cnt(rc2));

  typedef struct {
    logic [W1-1:0] dat;
    int            due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   mon_en = 1'b0;
  int   m_state = 0, m_cnt = 0;  // 0 IDLE, 1 SETTLE, 2 RUN

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every output cycle must match the queue head due in that cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v;
      exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      checks++;
      if (dout_valid !== exp_v) begin
        errors++;
        $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (dout !== sbq[0].dat) begin
          errors++;
          $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, dout, sbq[0].dat);
        end
        void'(sbq.pop_front());
      end
    end
  end

  function automatic logic [W1-1:0] model_conv(input logic [W1-1:0] d, input logic f);
    logic [W1-1:0] r;
    logic [SW-1:0] s;
    for (int i = 0; i < NCH * SR; i++) begin
      s = d[i*SW +: SW];
      if (f) s = s - SW'(512);
      r[i*SW +: SW] = s;
    end
    return r;
  endfunction

  function automatic logic [W1-1:0] rep(input logic [SW-1:0] v);
    logic [W1-1:0] r;
    for (int i = 0; i < NCH * SR; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  function automatic logic [W1-1:0] rnd_word();
    logic [W1-1:0] r;
    for (int i = 0; i < W1 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W1-1:0] ramp_word(input int j, input bit corrupt);
    logic [W1-1:0] r;
    int v;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < SR; k++) begin
        v = (c * 37 + j * SR + k) % 1024;
        r[(c*SR+k)*SW +: SW] = SW'(v);
      end
    if (corrupt) r[(2*SR+5)*SW] = ~r[(2*SR+5)*SW];
    return r;
  endfunction

  // Applies one input word for one clock edge; returns just after the following negedge.
  task automatic drive(input logic [W1-1:0] d, input logic v, input logic f,
                       input logic r, input logic ec);
    exp_t e;
    din = d; din_valid = v; fmt_signed = f; rst = r; err_clr = ec;
    if (r) sbq.delete();
    else if (v && m_state == 2) begin
      e.dat = model_conv(d, f);
      e.due = cyc + 1 + PD;
      sbq.push_back(e);
    end
    if (r) begin m_state = 0; m_cnt = 0; end
    else if (m_state == 0) m_state = 1;
    else if (m_state == 1 && v) begin
      m_cnt++;
      if (m_cnt == SC) m_state = 2;
    end
    @(negedge clk); #1;
  endtask

  task automatic bring_up();
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_state != 2; i++) drive(rnd_word(), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL bring_up_flag got=%b exp=1", flag);
    end
  endtask

  task automatic test_reset();
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks += 4;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", flag); end
    if (ramp_err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_ramp got=%h exp=0", ramp_err_cnt);
    end
  endtask

  task automatic test_settle();
    int rise = 0, fv = 0;
    for (int i = 1; i <= 24; i++) begin
      drive(rnd_word(), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (flag === 1'b1 && rise == 0) rise = i;
      if (dout_valid === 1'b1 && fv == 0) fv = i;
    end
    checks += 2;
    if (rise != 17) begin errors++; $display("FAIL settle_flag_cycle got=%0d exp=17", rise); end
    if (fv != 20) begin errors++; $display("FAIL settle_first_valid got=%0d exp=20", fv); end
  endtask

  task automatic test_conversion();
    logic [SW-1:0] vin [6];
    logic [SW-1:0] vexp[6];
    logic [W1-1:0] obs [8];
    logic          ov  [8];
    vin  = '{10'd0, 10'd512, 10'd1023, 10'd0, 10'd512, 10'd1023};
    vexp = '{10'h200, 10'h000, 10'h1FF, 10'd0, 10'd512, 10'd1023};
    for (int j = 0; j < 8; j++) begin
      if (j < 6) drive(rep(vin[j]), 1'b1, (j < 3), 1'b0, 1'b0);
      else       drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      obs[j] = dout; ov[j] = dout_valid;
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (ov[j+2] !== 1'b1 || obs[j+2] !== rep(vexp[j])) begin
        errors++;
        $display("FAIL conv_%0d got=%b/%h exp=1/%h", j, ov[j+2], obs[j+2][SW-1:0], vexp[j]);
      end
    end
  endtask

  task automatic test_gaps();
    logic pat[5];
    logic ov [8];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int j = 0; j < 8; j++) begin
      if (j < 5) drive(rnd_word(), pat[j], 1'b1, 1'b0, 1'b0);
      else       drive(rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0);
      ov[j] = dout_valid;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (ov[j+2] !== pat[j]) begin
        errors++;
        $display("FAIL gap_valid_%0d got=%b exp=%b", j, ov[j+2], pat[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 3; j++) drive(rnd_word(), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%b exp=1", dout_valid); end
    drive(rnd_word(), 1'b1, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", dout_valid); end
    if (dout !== '0) begin errors++; $display("FAIL mid_dout got=%h exp=0", dout); end
    if (flag !== 1'b0) begin errors++; $display("FAIL mid_flag got=%b exp=0", flag); end
    for (int j = 0; j < 6; j++) begin
      drive(rnd_word(), 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flag !== 1'b0) begin errors++; $display("FAIL mid_resettle_%0d got=%b exp=0", j, flag); end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] e1;
    e1 = 16'(RAMP_ON);
    drive(ramp_word(0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ramp_err_cnt !== 16'h0) begin errors++; $display("FAIL ramp_clr0 got=%h exp=0", ramp_err_cnt); end
    for (int j = 1; j < 140; j++) begin
      drive(ramp_word(j, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ramp_err_cnt !== 16'h0) begin
        errors++; $display("FAIL ramp_clean_%0d got=%h exp=0", j, ramp_err_cnt);
      end
    end
    drive(ramp_word(140, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ramp_err_cnt !== e1) begin errors++; $display("FAIL ramp_corrupt got=%h exp=%h", ramp_err_cnt, e1); end
    drive(ramp_word(141, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ramp_err_cnt !== e1) begin errors++; $display("FAIL ramp_hold got=%h exp=%h", ramp_err_cnt, e1); end
    drive(ramp_word(142, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ramp_err_cnt !== 16'h0) begin errors++; $display("FAIL ramp_clr_wins got=%h exp=0", ramp_err_cnt); end
    drive(ramp_word(143, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    drive(ramp_word(144, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ramp_err_cnt !== e1) begin errors++; $display("FAIL ramp_corrupt2 got=%h exp=%h", ramp_err_cnt, e1); end
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ramp_err_cnt !== 16'h0) begin errors++; $display("FAIL ramp_clr got=%h exp=0", ramp_err_cnt); end
  endtask

  task automatic test_param_sweep();
    logic [W2-1:0] e2;
    rst2 = 1'b1; dv2 = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst2 = 1'b0; dv2 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      din2 = {$urandom, $urandom, $urandom};
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (flag2 !== 1'b1) begin errors++; $display("FAIL sweep_flag got=%b exp=1", flag2); end
    din2 = '0; fmt2 = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) e2[i*12 +: 12] = 12'h800;
    checks++;
    if (dov2 !== 1'b1 || dout2 !== e2) begin
      errors++; $display("FAIL sweep_zero got=%b/%h exp=1/%h", dov2, dout2, e2);
    end
    for (int i = 0; i < 8; i++) din2[i*12 +: 12] = 12'hFFF;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) e2[i*12 +: 12] = 12'h7FF;
    checks++;
    if (dov2 !== 1'b1 || dout2 !== e2) begin
      errors++; $display("FAIL sweep_max got=%b/%h exp=1/%h", dov2, dout2, e2);
    end
    dv2 = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dov2 !== 1'b0) begin errors++; $display("FAIL sweep_gap got=%b exp=0", dov2); end
  endtask

  initial begin
    @(negedge clk); #1;
    test_reset();
    test_settle();
    test_conversion();
    test_gaps();
    test_reset_mid();
    bring_up();
    test_ramp();
    test_param_sweep();
    for (int j = 0; j < 4; j++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
